led_pattern_engine: RTL
=======================

Name: led_pattern_engine

Overview:
Parametrised LED pattern sequencer driving a WIDTH-bit LED bank from a free-running prescaler. It supports rotate-left, rotate-right, bounce (ping-pong) and thermometer-fill modes, plus pause and synchronous pattern load. It sits between the board clock and the LED pins and replaces the fixed 8-bit single-direction ripple.

Parameters:
WIDTH, 8, number of LEDs driven; legal range is 2 or more.
SHIFT_TIME, 50000000, clock cycles per pattern step; legal range is 1 or more; the period is exactly SHIFT_TIME cycles.
CNT_W, 32, prescaler counter width; must satisfy 2^CNT_W > SHIFT_TIME.

Ports:
clk  input  1  system clock; all state updates on its rising edge.
rst  input  1  synchronous, active-high reset.
enable  input  1  1 = prescaler runs; 0 = pause (counter and LEDs hold).
mode  input  2  00 rotate left, 01 rotate right, 10 bounce, 11 fill.
load  input  1  synchronous load strobe.
load_pattern  input  WIDTH  value written to led on load.
led  output  WIDTH  registered LED drive; bit 0 is the rightmost LED.
tick  output  1  registered one-cycle pulse, high in the first cycle a stepped pattern is visible.

Behaviour:
- Reset (rst=1 at a clk edge) gives: led = 1 (only bit 0 set), counter = 0, dir = LEFT, tick = 0. Reset overrides load and enable and may assert at any cycle; it aborts the period in progress.
- Priority at each edge, highest first: rst, then load, then step, then hold.
- Load (load=1, rst=0): led <= load_pattern; counter <= 0; dir <= LEFT; tick <= 0. Load is honoured regardless of enable.
- Prescaler: when enable=1, counter increments each cycle. A step occurs when enable=1 and counter == SHIFT_TIME-1; on that edge counter <= 0.
  - With SHIFT_TIME=1, a step occurs on every enabled cycle.
  - With enable=0, counter holds its value, no step occurs, and the period resumes from the held count.
- tick <= 1 on a step edge, otherwise 0. tick is never high for two consecutive cycles unless SHIFT_TIME=1 and enable stays high.
- Step action, using the mode sampled on the step edge; mode changes between steps have no other effect:
  - 00 rotate left: led <= {led[WIDTH-2:0], led[WIDTH-1]}.
  - 01 rotate right: led <= {led[0], led[WIDTH-1:1]}.
  - 10 bounce: logical shift with no wrap, zero-filled.
    - dir=LEFT and led[WIDTH-1]=1: dir <= RIGHT; led <= led >> 1.
    - dir=LEFT otherwise: led <= led << 1.
    - dir=RIGHT and led[0]=1: dir <= LEFT; led <= led << 1.
    - dir=RIGHT otherwise: led <= led >> 1.
    - The reversal and the opposite shift happen on the same edge, so the end LED is lit for exactly one period.
    - An all-zero led stays all-zero.
  - 11 fill: led all ones -> led <= 0; otherwise led <= {led[WIDTH-2:0], 1'b1}.
    - From reset: 0x01, 0x03, 0x07, ..., 0xFF, 0x00, 0x01, ...
- dir is internal state. It is only read and updated in bounce mode and is retained across mode changes; entering bounce resumes in the last dir.
- No combinational path exists from any input to led or tick; both are flops.

Test Plan:
Use WIDTH=8, SHIFT_TIME=4.
1. Hold rst for 2 cycles, then release with enable=1 and mode=00 -> led=0x01 at reset; 0x02 visible 4 cycles after release with tick high that cycle only; then 0x04, ...; 0x80 is followed by 0x01 (wrap).
2. mode=01 from reset -> led sequence 0x01, 0x80, 0x40, ..., one step per 4 cycles.
3. mode=10 from reset -> 0x01, 0x02, ..., 0x80, 0x40, ..., 0x01, 0x02; 0x80 and 0x01 each visible for exactly 4 cycles; 14 steps per full cycle.
4. mode=11 from reset -> 0x03, 0x07, 0x0F, 0x1F, 0x3F, 0x7F, 0xFF, 0x00, 0x01.
5. Pause and resume: drop enable for 10 cycles at counter=2 -> led and tick hold with no step; after enable returns, the step occurs 2 cycles later (counter continues from 2).
6. Load, rst collision and reset mid-bounce:
   - load=1 with load_pattern=0xA5 on the same edge as a step -> led=0xA5, no tick, next step 4 cycles later (rotate left gives 0x4B).
   - load and rst asserted together -> led=0x01.
   - rst asserted mid-bounce while dir=RIGHT -> the next bounce steps go left.

Source files
------------

// File: rtl/led_pattern_engine.sv
// LED pattern sequencer: a prescaler advances a WIDTH-bit LED bank through
// rotate-left, rotate-right, bounce or thermometer-fill patterns.
module led_pattern_engine #(
    parameter int WIDTH      = 8,
    parameter int SHIFT_TIME = 50000000,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [1:0]       mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_pattern,
    output logic [WIDTH-1:0] led,
    output logic             tick
);

    typedef enum logic [1:0] {
        MODE_ROL    = 2'b00,
        MODE_ROR    = 2'b01,
        MODE_BOUNCE = 2'b10,
        MODE_FILL   = 2'b11
    } mode_t;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_t;

    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(SHIFT_TIME - 1);

    logic [CNT_W-1:0] counter;
    dir_t             dir;
    logic             step;
    logic [WIDTH-1:0] next_led;
    dir_t             next_dir;

    assign step = enable && (counter == LAST_COUNT);

    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        next_led = led;
        next_dir = dir;
        unique case (mode_t'(mode))
            MODE_ROL: next_led = {led[WIDTH-2:0], led[WIDTH-1]};
            MODE_ROR: next_led = {led[0], led[WIDTH-1:1]};
            MODE_BOUNCE: begin
                // Reversal and the opposite shift share one edge, so each end LED lasts one period.
                if (dir == DIR_LEFT) begin
                    if (led[WIDTH-1]) begin
                        next_dir = DIR_RIGHT;
                        next_led = led >> 1;
                    end else begin
                        next_led = led << 1;
                    end
                end else begin
                    if (led[0]) begin
                        next_dir = DIR_LEFT;
                        next_led = led << 1;
                    end else begin
                        next_led = led >> 1;
                    end
                end
            end
            MODE_FILL: next_led = (&led) ? '0 : {led[WIDTH-2:0], 1'b1};
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            led     <= WIDTH'(1);
            counter <= '0;
            dir     <= DIR_LEFT;
            tick    <= 1'b0;
        end else if (load) begin
            led     <= load_pattern;
            counter <= '0;
            dir     <= DIR_LEFT;
            tick    <= 1'b0;
        end else begin
            tick <= step;
            if (step) begin
                counter <= '0;
                led     <= next_led;
                dir     <= next_dir;
            end else if (enable) begin
                counter <= counter + CNT_W'(1);
            end
        end
    end

endmodule
